// File: rtl/irq_controller_if.sv
// Register-bus and interrupt-line bundle between the SM83 core, its peripherals
// and irq_controller. The master side is the core/peripherals; the slave side is the controller.
interface irq_controller_if #(
    parameter int NUM_SRC = 5
);
    logic [15:0]        A;
    logic [7:0]         D_IN;
    logic [7:0]         D_OUT;
    logic               D_OE;
    logic               RD;
    logic               WR;
    logic [NUM_SRC-1:0] IRQ_SRC;
    logic [7:0]         CPU_IRQ_TRIG;
    logic [7:0]         CPU_IRQ_ACK;
    logic               IRQ_ANY;

    modport master (
        output A, D_IN, RD, WR, IRQ_SRC, CPU_IRQ_ACK,
        input  D_OUT, D_OE, CPU_IRQ_TRIG, IRQ_ANY
    );

    modport slave (
        input  A, D_IN, RD, WR, IRQ_SRC, CPU_IRQ_ACK,
        output D_OUT, D_OE, CPU_IRQ_TRIG, IRQ_ANY
    );
endinterface

// File: rtl/irq_controller.sv
// SM83 interrupt controller: IF (edge-latched requests) and IE registers, trigger vector to the core.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchroniser on every IRQ_SRC line.
module irq_controller #(
    parameter int          NUM_SRC = 5,
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input logic              CLK,
    input logic              RESET,
    irq_controller_if.slave  bus
);
    logic [NUM_SRC-1:0] r_if;
    logic [NUM_SRC-1:0] r_src_prev;
    logic [7:0]         r_ie;

    logic [NUM_SRC-1:0] w_src_s;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_if_next;
    logic [7:0]         w_trig;
    logic [7:0]         w_if_rd;
    logic               w_wr_if;
    logic               w_wr_ie;
    logic               w_rd_if;
    logic               w_rd_ie;
    logic               w_unused_ack;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.IRQ_SRC;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_s = r_sync2;
`else
    assign w_src_s = bus.IRQ_SRC;
`endif

    assign w_set   = w_src_s & ~r_src_prev;
    assign w_wr_if = bus.WR && (bus.A == IF_ADDR);
    assign w_wr_ie = bus.WR && (bus.A == IE_ADDR);
    assign w_rd_if = bus.RD && (bus.A == IF_ADDR);
    assign w_rd_ie = bus.RD && (bus.A == IE_ADDR);

    // Only the low NUM_SRC acknowledge bits have an IF bit to clear.
    assign w_unused_ack = &{1'b0, bus.CPU_IRQ_ACK};

    // A new request beats an acknowledge, which beats a CPU write.
    always_comb begin
        w_if_next = r_if;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_set[i]) begin
                w_if_next[i] = 1'b1;
            end else if (bus.CPU_IRQ_ACK[i]) begin
                w_if_next[i] = 1'b0;
            end else if (w_wr_if) begin
                w_if_next[i] = bus.D_IN[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_if       <= '0;
            r_src_prev <= '0;
            r_ie       <= 8'h00;
        end else begin
            r_if       <= w_if_next;
            r_src_prev <= w_src_s;
            if (w_wr_ie) begin
                r_ie <= bus.D_IN;
            end
        end
    end

    // Unimplemented IF bits read back as 1.
    always_comb begin
        w_trig  = 8'h00;
        w_if_rd = 8'hFF;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_trig[i]  = r_if[i] & r_ie[i];
            w_if_rd[i] = r_if[i];
        end
    end

    assign bus.CPU_IRQ_TRIG = w_trig;
    assign bus.IRQ_ANY      = |w_trig;
    assign bus.D_OE         = w_rd_if | w_rd_ie;
    assign bus.D_OUT        = w_rd_if ? w_if_rd : (w_rd_ie ? r_ie : 8'h00);
endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller with a byte-level reference model.
module tb_irq_controller;
    localparam int          NS   = 5;
    localparam logic [15:0] IFA  = 16'hFF0F;
    localparam logic [15:0] IEA  = 16'hFFFF;
    localparam logic [7:0]  MASK = 8'h1F;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    irq_controller_if #(.NUM_SRC(NS)) bus ();

    irq_controller #(.NUM_SRC(NS), .IF_ADDR(IFA), .IE_ADDR(IEA)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] trig;
        logic       any;
        logic [7:0] dout;
        logic       doe;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: IF/IE as bytes, previous sampled sources, synchroniser stages.
    logic [7:0] m_if, m_ie, m_prev, m_s1, m_s2;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_if = 8'h00; m_ie = 8'h00; m_prev = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
    endfunction

    // Applies one clock edge using the inputs that were stable before it.
    function automatic void model_edge();
        logic [7:0] src, set, nxt;
        if (rst) begin
            model_clear();
        end else begin
            src = 8'(bus.IRQ_SRC);
`ifdef IRQ_SYNC_EN
            set    = m_s2 & ~m_prev;
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = src;
`else
            set    = src & ~m_prev;
            m_prev = src;
`endif
            nxt  = (bus.WR && bus.A == IFA) ? bus.D_IN : m_if;
            nxt  = (nxt & ~bus.CPU_IRQ_ACK) | set;
            if (bus.WR && bus.A == IEA) m_ie = bus.D_IN;
            m_if = nxt & MASK;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.trig = m_if & m_ie & MASK;
        e.any  = |e.trig;
        e.dout = 8'h00;
        e.doe  = 1'b0;
        if (bus.RD && bus.A == IFA) begin
            e.dout = m_if | ~MASK;
            e.doe  = 1'b1;
        end else if (bus.RD && bus.A == IEA) begin
            e.dout = m_ie;
            e.doe  = 1'b1;
        end
        e.cyc = cyc;
        sb.push_back(e);
    endfunction

    task automatic cycle(input logic r, input logic [7:0] src, input logic [7:0] ack,
                         input logic [15:0] a, input logic [7:0] din,
                         input logic rd, input logic wr);
        @(posedge clk);
        #1;
        model_edge();
        rst = r;
        if (r) model_clear();
        bus.IRQ_SRC     = src[NS-1:0];
        bus.CPU_IRQ_ACK = ack;
        bus.A           = a;
        bus.D_IN        = din;
        bus.RD          = rd;
        bus.WR          = wr;
        cyc++;
        push_exp();
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("trig@%0d", e.cyc), bus.CPU_IRQ_TRIG, e.trig);
                chk($sformatf("any@%0d", e.cyc), {7'd0, bus.IRQ_ANY}, {7'd0, e.any});
                chk($sformatf("dout@%0d", e.cyc), bus.D_OUT, e.dout);
                chk($sformatf("doe@%0d", e.cyc), {7'd0, bus.D_OE}, {7'd0, e.doe});
            end
        end
    end

    initial begin
        logic [7:0]  src, ack, din, cur_src;
        logic [15:0] a;
        logic        r, rd, wr;

        model_clear();
        bus.IRQ_SRC = '1; bus.CPU_IRQ_ACK = 8'h00; bus.A = 16'h0000;
        bus.D_IN = 8'h00; bus.RD = 1'b0; bus.WR = 1'b0;

        // Sources held high across reset release set IF once reset is gone.
        cycle(1, 8'h1F, 0, 0, 0, 0, 0);
        cycle(1, 8'h1F, 0, 0, 0, 0, 0);
        #2; chk("rst_trig", bus.CPU_IRQ_TRIG, 8'h00);
        chk("rst_doe", {7'd0, bus.D_OE}, 8'h00);
        cycle(0, 8'h1F, 0, IFA, 0, 1, 0);
        #2; chk("rel_if_clear", bus.D_OUT, 8'hE0);
        repeat (LAT) cycle(0, 8'h1F, 0, IFA, 0, 1, 0);
        #2; chk("rel_if_ff", bus.D_OUT, 8'hFF);
        chk("rel_trig", bus.CPU_IRQ_TRIG, 8'h00);
        chk("rel_any", {7'd0, bus.IRQ_ANY}, 8'h00);

        // Single-cycle pulse on source 2, then acknowledge.
        cycle(0, 8'h00, 0, IEA, 8'h04, 0, 1);
        cycle(0, 8'h00, 0, IFA, 8'h00, 0, 1);
        cycle(0, 8'h04, 0, 0, 0, 0, 0);
        repeat (LAT) cycle(0, 8'h00, 0, 0, 0, 0, 0);
        #2; chk("pulse_trig", bus.CPU_IRQ_TRIG, 8'h04);
        cycle(0, 8'h00, 8'h04, IFA, 0, 1, 0);
        #2; chk("pre_ack_if", bus.D_OUT, 8'hE4);
        cycle(0, 8'h00, 8'h00, IFA, 0, 1, 0);
        #2; chk("ack_if", bus.D_OUT, 8'hE0);
        chk("ack_trig", bus.CPU_IRQ_TRIG, 8'h00);

        // Level held high requests only once; re-raise requests again.
        cycle(0, 8'h00, 0, IEA, 8'h01, 0, 1);
        for (int i = 0; i < 10; i++)
            cycle(0, 8'h01, (i == LAT) ? 8'h01 : 8'h00, IFA, 0, 1, 0);
        #2; chk("level_if", bus.D_OUT, 8'hE0);
        chk("level_trig", bus.CPU_IRQ_TRIG, 8'h00);
        cycle(0, 8'h00, 0, 0, 0, 0, 0);
        cycle(0, 8'h01, 0, 0, 0, 0, 0);
        repeat (LAT) cycle(0, 8'h01, 0, IFA, 0, 1, 0);
        #2; chk("reraise_trig", bus.CPU_IRQ_TRIG, 8'h01);
        chk("reraise_if", bus.D_OUT, 8'hE1);

        // New request, ack and IF write landing on the same edge.
        repeat (LAT - 1) cycle(0, 8'h03, 0, 0, 0, 0, 0);
        cycle(0, 8'h03, 8'h02, IFA, 8'h00, 0, 1);
        cycle(0, 8'h03, 0, IFA, 0, 1, 0);
        #2; chk("set_wins", bus.D_OUT, 8'hE2);

        // IE gating, IE readback, simultaneous read and write.
        cycle(0, 8'h03, 0, IEA, 8'h00, 0, 1);
        cycle(0, 8'h03, 0, IFA, 8'h1F, 0, 1);
        cycle(0, 8'h03, 0, IFA, 0, 1, 0);
        #2; chk("ie0_trig", bus.CPU_IRQ_TRIG, 8'h00);
        chk("if1f_read", bus.D_OUT, 8'hFF);
        cycle(0, 8'h03, 0, IEA, 8'hFF, 0, 1);
        cycle(0, 8'h03, 0, IEA, 0, 1, 0);
        #2; chk("ieff_trig", bus.CPU_IRQ_TRIG, 8'h1F);
        chk("ieff_any", {7'd0, bus.IRQ_ANY}, 8'h01);
        chk("ie_read", bus.D_OUT, 8'hFF);
        cycle(0, 8'h03, 0, IEA, 8'h5A, 1, 1);
        #2; chk("rdwr_old", bus.D_OUT, 8'hFF);
        cycle(0, 8'h03, 0, IEA, 0, 1, 0);
        #2; chk("rdwr_new", bus.D_OUT, 8'h5A);

        // Reset landing while a request is in flight.
        cycle(0, 8'h00, 0, IEA, 8'h10, 0, 1);
        cycle(0, 8'h10, 0, 0, 0, 0, 0);
        cycle(1, 8'h00, 0, 0, 0, 0, 0);
        #2; chk("midrst_trig", bus.CPU_IRQ_TRIG, 8'h00);
        cycle(1, 8'h00, 0, 0, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0, 0, 0);
        repeat (4) cycle(0, 8'h00, 0, IFA, 0, 1, 0);
        #2; chk("midrst_if", bus.D_OUT, 8'hE0);

        // Source-to-trigger latency.
        cycle(0, 8'h00, 0, IEA, 8'h10, 0, 1);
        cycle(0, 8'h10, 0, 0, 0, 0, 0);
        repeat (LAT - 1) cycle(0, 8'h10, 0, 0, 0, 0, 0);
        #2; chk("lat_early", bus.CPU_IRQ_TRIG, 8'h00);
        cycle(0, 8'h10, 0, 0, 0, 0, 0);
        #2; chk("lat_hit", bus.CPU_IRQ_TRIG, 8'h10);

        // Randomised traffic.
        cur_src = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) cur_src = 8'($urandom);
            src = cur_src;
            ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            case ($urandom_range(0, 2))
                0:       a = IFA;
                1:       a = IEA;
                default: a = 16'($urandom);
            endcase
            din = 8'($urandom);
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) == 0);
            cycle(r, src, ack, a, din, rd, wr);
        end

        cycle(0, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_drained", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller for the SM83 core.
- Latches peripheral interrupt requests into the IF register (0xFF0F) and holds the IE register (0xFFFF).
- Drives the core's CPU_IRQ_TRIG vector and clears IF bits when the core returns CPU_IRQ_ACK.
- Sits between the peripheral blocks (VBlank, STAT, Timer, Serial, Joypad) and the core, and answers CPU register accesses on the internal bus.

Parameters:
NUM_SRC, 5, number of interrupt sources (bits 0..NUM_SRC-1; max 8)
IF_ADDR, 16'hFF0F, address of the IF register
IE_ADDR, 16'hFFFF, address of the IE register

Ports:
CLK  input  1  core clock
RESET  input  1  asynchronous, active-high reset
A  input  16  CPU address bus
D_IN  input  8  CPU write data
D_OUT  output  8  read data (0x00 when D_OE=0)
D_OE  output  1  high while a register read hits IF_ADDR or IE_ADDR
RD  input  1  CPU read strobe (level, active-high)
WR  input  1  CPU write strobe (single-cycle, active-high, sampled on posedge CLK)
IRQ_SRC  input  NUM_SRC  peripheral request lines (level; rising edge requests)
CPU_IRQ_TRIG  output  8  pending & enabled vector to core
CPU_IRQ_ACK  input  8  one-hot acknowledge from core
IRQ_ANY  output  1  OR of CPU_IRQ_TRIG (HALT/STOP wake)

Behaviour:
- Reset (asynchronous, immediate on RESET=1):
  - IF=0, IE=0, src_prev=0, synchroniser flops=0.
  - Outputs: CPU_IRQ_TRIG=0, IRQ_ANY=0, D_OE=0, D_OUT=0.
- Edge detect, per bit i<NUM_SRC, on each posedge CLK:
  - set_i = IRQ_SRC_s[i] & ~src_prev[i]; then src_prev <= IRQ_SRC_s.
  - IRQ_SRC_s is IRQ_SRC, or its synchronised version when IRQ_SYNC_EN is defined.
  - A level held high sets IF once only; it must fall and rise again to re-request.
- IF update per bit, priority highest first:
  1. set_i -> IF[i] <= 1
  2. CPU_IRQ_ACK[i] -> IF[i] <= 0
  3. WR & A==IF_ADDR -> IF[i] <= D_IN[i]
  4. otherwise hold
- IF bits i>=NUM_SRC are never stored.
- IE update: WR & A==IE_ADDR -> IE <= D_IN (all 8 bits stored and readable; only bits <NUM_SRC affect TRIG).
- CPU_IRQ_TRIG: combinational from registers.
  - CPU_IRQ_TRIG[i] = IF[i] & IE[i] for i<NUM_SRC; 0 for all other bits.
  - No priority encoding here; the core arbitrates.
- IRQ_ANY = |CPU_IRQ_TRIG.
- Latency: IRQ_SRC rises before posedge k -> IF bit and CPU_IRQ_TRIG visible after posedge k (1 cycle).
- Read path: combinational.
  - RD & A==IF_ADDR -> D_OUT = {unused bits forced 1, IF} (NUM_SRC=5 gives 0xE0|IF); D_OE=1.
  - RD & A==IE_ADDR -> D_OUT = IE; D_OE=1.
  - Otherwise D_OUT=0, D_OE=0.
- Multi-hot CPU_IRQ_ACK: clears every acked bit; not an error.
- ACK on a bit whose IF is already 0: no effect.
- RD and WR high together: the write takes effect at the edge; the read returns the pre-edge value.
- RESET asserted mid-operation: all state cleared immediately. A source held high through reset release sets IF one cycle after release, because src_prev resets to 0.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: each IRQ_SRC bit passes a 2-flop synchroniser (reset to 0) before edge detect.
  - Source-to-TRIG latency becomes 3 cycles.
  - Pulses shorter than one CLK period may be lost.
- Undefined: IRQ_SRC is used directly; latency 1 cycle; the source must be synchronous to CLK.

Test Plan:
- Reset with IRQ_SRC=5'b11111, IE=0 -> after release: IF reads 0xFF, CPU_IRQ_TRIG=0x00, IRQ_ANY=0.
- Write IE=0x04, pulse IRQ_SRC[2] for one cycle -> TRIG=0x04 next cycle. Assert ACK=0x04 -> IF reads 0xE0 and TRIG=0x00 next cycle.
- Hold IRQ_SRC[0] high 10 cycles, IE=0x01, ACK after first set -> IF[0] stays 0 for the remaining cycles. Drop and re-raise -> IF[0]=1 again.
- Same cycle: IRQ_SRC[1] rising edge, ACK=0x02, write IF=0x00 -> IF reads 0xE2 (set wins).
- Write IF=0x1F with IE=0x00 -> TRIG=0x00. Write IE=0xFF -> TRIG=0x1F, IRQ_ANY=1; IE reads back 0xFF.
- With IRQ_SYNC_EN: IRQ_SRC[4] rises before posedge k -> TRIG[4] first high after posedge k+2. Assert RESET mid-synchroniser -> no IF set.
